zero_cross_detector: RTL and testbench
======================================

// Module: zero_cross_detector
// PURPOSE
//  Clocked, parametrised hysteresis zero-crossing detector for sampled ADC data.
//  Converts a signed sample stream into a debounced square wave, flags its edges
//  and measures the clk-cycle period between rising edges.
//  Sits between the ADC sample interface and the phase/frequency logic.
// PARAMETERS
//  DATA_W    32  sample width, signed two's complement
//  DEBOUNCE   3  consecutive qualifying samples required to switch (>=1)
//  PERIOD_W  24  width of the period counter and period output
// PORTS
//  clk           in   1         single clock, all logic on rising edge
//  rst           in   1         synchronous reset, active-high
//  din_valid     in   1         din holds a new sample this cycle
//  din           in   DATA_W    signed ADC sample
//  thresh        in   DATA_W-1  unsigned hysteresis half-band, held static during run
//  square        out  1         debounced square wave
//  rise_pulse    out  1         1-cycle strobe on square 0->1
//  fall_pulse    out  1         1-cycle strobe on square 1->0
//  period        out  PERIOD_W  clk cycles between the last two rising edges
//  period_valid  out  1         1-cycle strobe when period is updated
//  period_ovf    out  1         sticky until next update: last period saturated
//  los           out  1         loss-of-signal, see CONFIGURATION
// BEHAVIOUR
//  - Reset: square=0, rise/fall_pulse=0, period=0, period_valid=0, period_ovf=0,
//    los=0, FSM=LOW, debounce count=0, period counter=0, armed=0.
//    rst has priority over every other event in the same cycle.
//  - Compare: HI = din > +thresh; LO = din < -thresh (sign-extend thresh to DATA_W,
//    strict compare). A sample equal to +/-thresh is in-band.
//  - FSM (advances only when din_valid=1; din_valid=0 holds state and count):
//    LOW: HI -> PEND_H, cnt=1 (DEBOUNCE=1: direct to HIGH). Else stay.
//    PEND_H: HI -> cnt+1; at cnt==DEBOUNCE -> HIGH. Not HI -> LOW, cnt=0.
//    HIGH / PEND_L: mirror of LOW / PEND_H with LO.
//  - square is registered: it changes on the clk edge after the cycle that
//    presents the DEBOUNCE-th qualifying sample. rise/fall_pulse assert in that
//    same cycle for exactly one clk.
//  - In-band samples never change square.
//  - Period counter: increments every clk, saturates at 2^PERIOD_W-1 (no wrap).
//    On each rise it restarts at 1 (the rise cycle counts as cycle 1).
//    When armed=1 it first loads period<=counter and pulses period_valid.
//    period_ovf <= (counter == all-ones). First rise after reset sets armed=1,
//    with no period_valid.
//  - Falling edges do not affect the period counter.
// CONFIGURATION
//  - Macro ZC_LOS_EN defined: los=1 from the cycle after the period counter
//    saturates, held until the next rise_pulse cycle, then 0. Also clears on rst.
//  - Macro ZC_LOS_EN undefined: los tied to 0, no extra logic.
// TESTING  (DEBOUNCE=3, thresh=50 unless noted)
//  1 rst=1 for 2 clk with din=1000, din_valid=1
//    -> all outputs 0, square remains 0 the cycle after rst drops
//  2 valid samples 60,60,60
//    -> square=1 one clk after third sample; rise_pulse high exactly 1 clk
//  3 valid 60,60,20,60,60 / invalid gaps between valid 60s
//    -> no switch until 3 consecutive valid 60s; gaps do not reset count
//  4 in HIGH, valid samples -50,0,50,-49 repeated
//    -> square stays 1; then -51 x3 -> square=0, fall_pulse 1 clk
//  5 clean square input, 1000-clk period, 4 cycles
//    -> no period_valid on 1st rise; period=1000 with period_valid on rises 2-4
//  6 PERIOD_W=8, one rise then 300 clk with no edge
//    -> next rise gives period=255, period_ovf=1; los=1 from saturation until
//       that rise (ZC_LOS_EN), los=0 throughout otherwise

Source files
------------

// File: rtl/zero_cross_detector_if.sv
// Sample/result bundle for the zero-crossing detector.
// master drives samples and threshold; slave (the detector) drives results.
interface zero_cross_detector_if #(
  parameter int DATA_W   = 32,
  parameter int PERIOD_W = 24
);
  logic                din_valid;
  logic [DATA_W-1:0]   din;
  logic [DATA_W-2:0]   thresh;
  logic                square;
  logic                rise_pulse;
  logic                fall_pulse;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                period_ovf;
  logic                los;

  modport master (
    output din_valid, din, thresh,
    input  square, rise_pulse, fall_pulse, period, period_valid, period_ovf, los
  );

  modport slave (
    input  din_valid, din, thresh,
    output square, rise_pulse, fall_pulse, period, period_valid, period_ovf, los
  );
endinterface

// File: rtl/zero_cross_detector.sv
// Hysteresis zero-crossing detector: debounced square wave, edge strobes, rise-to-rise period.
// Define ZC_LOS_EN to enable the loss-of-signal output (otherwise los is tied low).
//
// state  | meaning
// LOW    | square low, waiting for a sample above +thresh
// PEND_H | square low, counting consecutive samples above +thresh
// HIGH   | square high, waiting for a sample below -thresh
// PEND_L | square high, counting consecutive samples below -thresh
module zero_cross_detector #(
  parameter int DATA_W   = 32,
  parameter int DEBOUNCE = 3,
  parameter int PERIOD_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  zero_cross_detector_if.slave  zc
);

  localparam int                  CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0]    DB_CNT = CNT_W'(DEBOUNCE);
  localparam logic [PERIOD_W-1:0] P_MAX  = '1;

  typedef enum logic [1:0] {LOW, PEND_H, HIGH, PEND_L} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                square_q, square_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pvalid_q, pvalid_d;
  logic                povf_q, povf_d;
  logic                armed_q, armed_d;

  logic signed [DATA_W-1:0] th_pos, th_neg, din_s;
  logic                     hi, lo;

  // thresh is unsigned and one bit narrower, so its negation always fits
  assign th_pos  = $signed({1'b0, zc.thresh});
  assign th_neg  = -th_pos;
  assign din_s   = $signed(zc.din);
  assign hi      = din_s > th_pos;
  assign lo      = din_s < th_neg;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (zc.din_valid) begin
      case (state_q)
        LOW: if (hi) begin
          if (DEBOUNCE == 1) begin
            state_d = HIGH;
            rise_d  = 1'b1;
          end else begin
            state_d = PEND_H;
            cnt_d   = CNT_W'(1);
          end
        end
        PEND_H: if (hi) begin
          if (cnt_inc == DB_CNT) begin
            state_d = HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = LOW;
          cnt_d   = '0;
        end
        HIGH: if (lo) begin
          if (DEBOUNCE == 1) begin
            state_d = LOW;
            fall_d  = 1'b1;
          end else begin
            state_d = PEND_L;
            cnt_d   = CNT_W'(1);
          end
        end
        PEND_L: if (lo) begin
          if (cnt_inc == DB_CNT) begin
            state_d = LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = HIGH;
          cnt_d   = '0;
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    square_d = square_q;
    if (rise_d) square_d = 1'b1;
    if (fall_d) square_d = 1'b0;

    pcnt_d   = (pcnt_q == P_MAX) ? pcnt_q : pcnt_q + PERIOD_W'(1);
    period_d = period_q;
    povf_d   = povf_q;
    pvalid_d = 1'b0;
    armed_d  = armed_q;
    // the rise cycle itself is cycle 1 of the next period
    if (rise_d) begin
      pcnt_d  = PERIOD_W'(1);
      armed_d = 1'b1;
      if (armed_q) begin
        period_d = pcnt_q;
        povf_d   = (pcnt_q == P_MAX);
        pvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOW;
      cnt_q    <= '0;
      square_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pcnt_q   <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      povf_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      square_q <= square_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
      povf_q   <= povf_d;
      armed_q  <= armed_d;
    end
  end

  assign zc.square       = square_q;
  assign zc.rise_pulse   = rise_q;
  assign zc.fall_pulse   = fall_q;
  assign zc.period       = period_q;
  assign zc.period_valid = pvalid_q;
  assign zc.period_ovf   = povf_q;

`ifdef ZC_LOS_EN
  logic los_q, los_d;

  // counter stays saturated until a rise, so los simply follows it
  always_comb begin
    los_d = !rise_d && (pcnt_q == P_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) los_q <= 1'b0;
    else     los_q <= los_d;
  end

  assign zc.los = los_q;
`else
  assign zc.los = 1'b0;
`endif

endmodule

// File: tb/tb_zero_cross_detector.sv
// Bench for zero_cross_detector: directed scenarios plus randomized run against a spec-level model.
// Two instances share stimulus: 24-bit and 8-bit period counters.
module tb_zero_cross_detector;

  localparam int  DB   = 3;
  localparam longint MAXA = (64'd1 << 24) - 1;
  localparam longint MAXB = 255;

  logic               clk = 1'b0;
  logic               rst;
  logic               din_valid;
  logic signed [31:0] din;
  logic [30:0]        thresh;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zero_cross_detector_if #(.DATA_W(32), .PERIOD_W(24)) ifa ();
  zero_cross_detector_if #(.DATA_W(32), .PERIOD_W(8))  ifb ();

  assign ifa.din_valid = din_valid;
  assign ifa.din       = din;
  assign ifa.thresh    = thresh;
  assign ifb.din_valid = din_valid;
  assign ifb.din       = din;
  assign ifb.thresh    = thresh;

  zero_cross_detector #(.DATA_W(32), .DEBOUNCE(DB), .PERIOD_W(24)) dut_a (
    .clk(clk), .rst(rst), .zc(ifa)
  );
  zero_cross_detector #(.DATA_W(32), .DEBOUNCE(DB), .PERIOD_W(8)) dut_b (
    .clk(clk), .rst(rst), .zc(ifb)
  );

  // Reference model: square toggles after DB consecutive valid samples beyond the
  // band on the opposite side; period derived from the cycle index of rises.
  int     kc = 0;
  int     base_m, run_m;
  bit     sq_m, armed_m, rise_m, fall_m, pv_m, ovf_a_m, ovf_b_m, los_a_m, los_b_m;
  longint per_a_m, per_b_m;

  always @(posedge clk) begin
    longint dv, th, elapsed;
    bit     q;
    kc++;
    if (rst) begin
      sq_m = 0; run_m = 0; armed_m = 0; base_m = kc;
      rise_m = 0; fall_m = 0; pv_m = 0;
      per_a_m = 0; per_b_m = 0; ovf_a_m = 0; ovf_b_m = 0; los_a_m = 0; los_b_m = 0;
    end else begin
      rise_m = 0; fall_m = 0; pv_m = 0;
      dv = din;
      th = thresh;
      if (din_valid) begin
        q = sq_m ? (dv < -th) : (dv > th);
        run_m = q ? run_m + 1 : 0;
        if (run_m == DB) begin
          sq_m   = !sq_m;
          run_m  = 0;
          rise_m = sq_m;
          fall_m = !sq_m;
        end
      end
      elapsed = kc - 1 - base_m;
      if (rise_m) begin
        if (armed_m) begin
          per_a_m = (elapsed >= MAXA) ? MAXA : elapsed;
          per_b_m = (elapsed >= MAXB) ? MAXB : elapsed;
          ovf_a_m = (elapsed >= MAXA);
          ovf_b_m = (elapsed >= MAXB);
          pv_m    = 1;
        end
        armed_m = 1;
        base_m  = kc - 1;
        los_a_m = 0;
        los_b_m = 0;
      end else begin
`ifdef ZC_LOS_EN
        los_a_m = (elapsed >= MAXA);
        los_b_m = (elapsed >= MAXB);
`else
        los_a_m = 0;
        los_b_m = 0;
`endif
      end
    end
  end

  task automatic tick(input logic v, input logic signed [31:0] d);
    din_valid = v;
    din       = d;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [30:0] th);
    rst = 1'b1; din_valid = 1'b0; din = '0; thresh = th;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] fa, fb;
    rst = 1'b1; thresh = 31'd50; din_valid = 1'b1; din = 32'sd1000;
    @(negedge clk);
    @(negedge clk);
    fa = {ifa.square, ifa.rise_pulse, ifa.fall_pulse, ifa.period_valid, ifa.period_ovf, ifa.los};
    fb = {ifb.square, ifb.rise_pulse, ifb.fall_pulse, ifb.period_valid, ifb.period_ovf, ifb.los};
    n_checks++;
    if (fa !== 6'b0) begin n_fail++; $display("FAIL reset_flags_a got=%b exp=000000", fa); end
    n_checks++;
    if (fb !== 6'b0) begin n_fail++; $display("FAIL reset_flags_b got=%b exp=000000", fb); end
    n_checks++;
    if (ifa.period !== 24'd0) begin n_fail++; $display("FAIL reset_period_a got=%0d exp=0", ifa.period); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifa.square !== 1'b0) begin n_fail++; $display("FAIL reset_release_square got=%b exp=0", ifa.square); end
  endtask

  task automatic test_debounce();
    do_reset(31'd50);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 32'sd60);
      n_checks++;
      if (ifa.square !== (i == 2) || ifa.rise_pulse !== (i == 2)) begin
        n_fail++;
        $display("FAIL debounce_rise i=%0d got sq=%b rp=%b exp=%b", i, ifa.square, ifa.rise_pulse, (i == 2));
      end
    end
    tick(1'b0, 32'sd0);
    n_checks++;
    if (ifa.square !== 1'b1 || ifa.rise_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL debounce_pulse_width got sq=%b rp=%b exp sq=1 rp=0", ifa.square, ifa.rise_pulse);
    end
  endtask

  task automatic test_gaps();
    int dv[5] = '{60, 60, 20, 60, 60};
    bit gv[6] = '{1, 0, 1, 0, 0, 1};
    do_reset(31'd50);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, dv[i]);
      n_checks++;
      if (ifa.square !== 1'b0) begin n_fail++; $display("FAIL inband_breaks_run i=%0d got=%b exp=0", i, ifa.square); end
    end
    do_reset(31'd50);
    for (int i = 0; i < 6; i++) begin
      tick(gv[i], gv[i] ? 32'sd60 : -32'sd1000);
      n_checks++;
      if (ifa.square !== (i == 5) || ifa.rise_pulse !== (i == 5)) begin
        n_fail++;
        $display("FAIL gaps_hold_count i=%0d got sq=%b rp=%b exp=%b", i, ifa.square, ifa.rise_pulse, (i == 5));
      end
    end
  endtask

  task automatic test_hysteresis();
    int pat[4] = '{-50, 0, 50, -49};
    do_reset(31'd50);
    for (int i = 0; i < 3; i++) tick(1'b1, 32'sd60);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        tick(1'b1, pat[i]);
        n_checks++;
        if (ifa.square !== 1'b1 || ifa.fall_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL inband_hold v=%0d got sq=%b fp=%b exp sq=1 fp=0", pat[i], ifa.square, ifa.fall_pulse);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, -32'sd51);
      n_checks++;
      if (ifa.square !== (i < 2) || ifa.fall_pulse !== (i == 2)) begin
        n_fail++;
        $display("FAIL fall_debounce i=%0d got sq=%b fp=%b exp sq=%b fp=%b", i, ifa.square, ifa.fall_pulse, (i < 2), (i == 2));
      end
    end
  endtask

  task automatic test_period();
    int rises = 0;
    do_reset(31'd50);
    for (int c = 0; c < 4000; c++) begin
      tick(1'b1, ((c % 1000) < 500) ? 32'sd1000 : -32'sd1000);
      if (ifa.rise_pulse === 1'b1) begin
        rises++;
        n_checks++;
        if (ifa.period_valid !== (rises > 1)) begin
          n_fail++;
          $display("FAIL period_valid_on_rise rise=%0d got=%b exp=%b", rises, ifa.period_valid, (rises > 1));
        end
        if (rises > 1) begin
          n_checks++;
          if (ifa.period !== 24'd1000 || ifa.period_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL period_1000 rise=%0d got=%0d ovf=%b exp=1000 ovf=0", rises, ifa.period, ifa.period_ovf);
          end
          n_checks++;
          if (ifb.period !== 8'd255 || ifb.period_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL period_sat8 rise=%0d got=%0d ovf=%b exp=255 ovf=1", rises, ifb.period, ifb.period_ovf);
          end
        end
      end else begin
        n_checks++;
        if (ifa.period_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL period_valid_stray c=%0d got=1 exp=0", c);
        end
      end
    end
    n_checks++;
    if (rises != 4) begin n_fail++; $display("FAIL rise_count got=%0d exp=4", rises); end
  endtask

  task automatic test_saturation();
    localparam int D = 303;
    logic signed [31:0] s;
    bit exp_los;
    do_reset(31'd50);
    for (int i = 0; i < 3; i++) tick(1'b1, 32'sd60);
    n_checks++;
    if (ifb.rise_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_first_rise got=%b exp=1", ifb.rise_pulse); end
    for (int j = 1; j <= D; j++) begin
      if (j - 1 < 3)            s = -32'sd60;
      else if (j - 1 >= D - 3)  s = 32'sd60;
      else                      s = 32'sd0;
      tick(1'b1, s);
`ifdef ZC_LOS_EN
      exp_los = (j >= 255) && (j != D);
`else
      exp_los = 1'b0;
`endif
      n_checks++;
      if (ifb.los !== exp_los || ifa.los !== 1'b0) begin
        n_fail++;
        $display("FAIL los j=%0d got b=%b a=%b exp b=%b a=0", j, ifb.los, ifa.los, exp_los);
      end
    end
    n_checks++;
    if (ifb.rise_pulse !== 1'b1 || ifb.period_valid !== 1'b1 || ifb.period !== 8'd255 || ifb.period_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_period_b got rp=%b pv=%b p=%0d ovf=%b exp 1 1 255 1",
               ifb.rise_pulse, ifb.period_valid, ifb.period, ifb.period_ovf);
    end
    n_checks++;
    if (ifa.period !== 24'(D) || ifa.period_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_period_a got=%0d ovf=%b exp=%0d ovf=0", ifa.period, ifa.period_ovf, D);
    end
  endtask

  task automatic test_random(input int th, input int n);
    bit         mode = 0;
    int         d;
    logic [5:0] ga, ea, gb, eb;
    do_reset(31'(th));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 39) == 0) mode = !mode;
      case ($urandom_range(0, 9))
        0: d = th;
        1: d = -th;
        2: d = th + 1;
        3: d = -th - 1;
        4: d = int'($urandom_range(0, 2 * th)) - th;
        5: d = int'($urandom());
        default: d = mode ? th + 1 + int'($urandom_range(0, 1000)) : -th - 1 - int'($urandom_range(0, 1000));
      endcase
      rst = ($urandom_range(0, 599) == 0);
      tick($urandom_range(0, 3) != 0, d);
      ga = {ifa.square, ifa.rise_pulse, ifa.fall_pulse, ifa.period_valid, ifa.period_ovf, ifa.los};
      ea = {sq_m, rise_m, fall_m, pv_m, ovf_a_m, los_a_m};
      gb = {ifb.square, ifb.rise_pulse, ifb.fall_pulse, ifb.period_valid, ifb.period_ovf, ifb.los};
      eb = {sq_m, rise_m, fall_m, pv_m, ovf_b_m, los_b_m};
      n_checks++;
      if (ga !== ea || ifa.period !== 24'(per_a_m)) begin
        n_fail++;
        $display("FAIL rand_a th=%0d i=%0d got flags=%b p=%0d exp flags=%b p=%0d", th, i, ga, ifa.period, ea, per_a_m);
      end
      n_checks++;
      if (gb !== eb || ifb.period !== 8'(per_b_m)) begin
        n_fail++;
        $display("FAIL rand_b th=%0d i=%0d got flags=%b p=%0d exp flags=%b p=%0d", th, i, gb, ifb.period, eb, per_b_m);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0; thresh = 31'd50;
    test_reset();
    test_debounce();
    test_gaps();
    test_hysteresis();
    test_period();
    test_saturation();
    test_random(int'($urandom_range(1, 200)), 3000);
    test_random(0, 2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
